// File: rtl/dec_blk_framer_if.sv
// Gearbox-side and comparator-side signals of the decoder block framer.
interface dec_blk_framer_if;
    logic [31:0] RX_DATA;
    logic        RX_VAL;
    logic        SLIP;
    logic        FEC_LOCK;
    logic [31:0] BLK_DATA;
    logic        BLK_VAL;
    logic        BLK_SOB;
    logic        BLK_EOB;
    logic [31:0] T_CRC;
    logic        T_CRC_ENA;
    logic [4:0]  BIT_OFS;
    logic [15:0] SLIP_CNT;

    modport master (
        output RX_DATA, RX_VAL, SLIP, FEC_LOCK,
        input  BLK_DATA, BLK_VAL, BLK_SOB, BLK_EOB, T_CRC, T_CRC_ENA, BIT_OFS, SLIP_CNT
    );

    modport slave (
        input  RX_DATA, RX_VAL, SLIP, FEC_LOCK,
        output BLK_DATA, BLK_VAL, BLK_SOB, BLK_EOB, T_CRC, T_CRC_ENA, BIT_OFS, SLIP_CNT
    );
endinterface

// File: rtl/dec_blk_framer.sv
// Bit/word aligner and FEC block framer ahead of the CRC comparator.
// Define DEC_FRAMER_SLIP_CNT_EN to build the saturating applied-slip counter.
module dec_blk_framer #(
    parameter int BLK_WORDS = 66,
    parameter int WCNT_W    = 7
) (
    input  logic             CLK,
    input  logic             RST,
    dec_blk_framer_if.slave  bus
);

    typedef enum logic {ST_PASS, ST_DROP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              emit;
    logic              slip_ok;
    logic              word_last;
    logic [31:0]       prev_word;
    logic [4:0]        bit_ofs;
    logic [WCNT_W-1:0] word_cnt;
    logic [63:0]       shifted;
    logic [31:0]       aligned;
    logic [31:0]       blk_data_q;
    logic              blk_val_q;
    logic              blk_sob_q;
    logic              blk_eob_q;
    logic [31:0]       t_crc_q;
    logic              t_crc_ena_q;

    // Slips are refused while locked or while a wrap-induced word drop is outstanding.
    assign slip_ok   = bus.SLIP & ~bus.FEC_LOCK & (state == ST_PASS);
    assign word_last = (word_cnt == WCNT_W'(BLK_WORDS - 1));
    assign shifted   = {prev_word, bus.RX_DATA} << bit_ofs;
    assign aligned   = shifted[63:32];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_PASS;
        end else begin
            state <= state_nxt;
        end
    end

    // A slip at offset 31 wraps to 0; the next valid word is swallowed to complete the one-bit advance.
    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        case (state)
            ST_PASS: begin
                emit = bus.RX_VAL;
                if (slip_ok && (bit_ofs == 5'd31)) begin
                    state_nxt = ST_DROP;
                end
            end
            ST_DROP: begin
                if (bus.RX_VAL) begin
                    state_nxt = ST_PASS;
                end
            end
            default: state_nxt = ST_PASS;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_word   <= '0;
            bit_ofs     <= '0;
            word_cnt    <= '0;
            blk_data_q  <= '0;
            blk_val_q   <= 1'b0;
            blk_sob_q   <= 1'b0;
            blk_eob_q   <= 1'b0;
            t_crc_q     <= '0;
            t_crc_ena_q <= 1'b0;
        end else begin
            if (bus.RX_VAL) begin
                prev_word <= bus.RX_DATA;
            end
            if (slip_ok) begin
                bit_ofs <= bit_ofs + 5'd1;
            end
            blk_val_q   <= emit;
            blk_sob_q   <= emit & (word_cnt == '0);
            blk_eob_q   <= emit & word_last;
            t_crc_ena_q <= emit & word_last;
            if (emit) begin
                blk_data_q <= aligned;
                word_cnt   <= word_last ? '0 : word_cnt + 1'b1;
                if (word_last) begin
                    t_crc_q <= aligned;
                end
            end
        end
    end

`ifdef DEC_FRAMER_SLIP_CNT_EN
    logic [15:0] slip_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            slip_cnt_q <= '0;
        end else if (slip_ok && (slip_cnt_q != 16'hFFFF)) begin
            slip_cnt_q <= slip_cnt_q + 16'd1;
        end
    end

    assign bus.SLIP_CNT = slip_cnt_q;
`else
    assign bus.SLIP_CNT = 16'd0;
`endif

    assign bus.BLK_DATA  = blk_data_q;
    assign bus.BLK_VAL   = blk_val_q;
    assign bus.BLK_SOB   = blk_sob_q;
    assign bus.BLK_EOB   = blk_eob_q;
    assign bus.T_CRC     = t_crc_q;
    assign bus.T_CRC_ENA = t_crc_ena_q;
    assign bus.BIT_OFS   = bit_ofs;

endmodule

// File: tb/tb_dec_blk_framer.sv
// Scoreboard bench for dec_blk_framer: a behavioural model queues expected words as stimulus is driven.
module tb_dec_blk_framer;

    typedef struct packed {
        logic [31:0] data;
        logic        sob;
        logic        eob;
    } exp_t;

    logic CLK;
    logic RST;
    dec_blk_framer_if bus();

    dec_blk_framer #(.BLK_WORDS(66), .WCNT_W(7)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    exp_t        exp_q[$];
    exp_t        e;
    logic        hit;
    int          n_tests;
    int          n_fail;
    logic [31:0] m_prev;
    logic [4:0]  m_ofs;
    int          m_cnt;
    logic        m_drop;
    logic [15:0] m_slips;
    logic [31:0] m_tcrc;

    function automatic logic [31:0] window(input logic [31:0] p, input logic [31:0] d, input logic [4:0] o);
        logic [63:0] c;
        c = {p, d};
        return c[63 - o -: 32];
    endfunction

    function automatic logic [15:0] slip_exp();
`ifdef DEC_FRAMER_SLIP_CNT_EN
        return m_slips;
`else
        return 16'd0;
`endif
    endfunction

    task automatic model_reset();
        m_prev  = '0;
        m_ofs   = '0;
        m_cnt   = 0;
        m_drop  = 1'b0;
        m_slips = '0;
        m_tcrc  = '0;
        exp_q.delete();
    endtask

    // Drives one cycle of stimulus, advances the model, and leaves time 1 unit after the edge.
    task automatic step(input logic val, input logic [31:0] data, input logic slip, input logic lock);
        logic accept;
        logic [31:0] w;
        bus.RX_VAL   = val;
        bus.RX_DATA  = data;
        bus.SLIP     = slip;
        bus.FEC_LOCK = lock;
        accept = slip && !lock && !m_drop;
        if (val) begin
            if (m_drop) begin
                m_drop = 1'b0;
            end else begin
                w = window(m_prev, data, m_ofs);
                exp_q.push_back('{data: w, sob: (m_cnt == 0), eob: (m_cnt == 65)});
                if (m_cnt == 65) m_tcrc = w;
                m_cnt = (m_cnt + 1) % 66;
            end
            m_prev = data;
        end
        if (accept) begin
            if (m_slips != 16'hFFFF) m_slips = m_slips + 16'd1;
            if (m_ofs == 5'd31) begin
                m_ofs  = 5'd0;
                m_drop = 1'b1;
            end else begin
                m_ofs = m_ofs + 5'd1;
            end
        end
        @(posedge CLK);
        #1;
        bus.RX_VAL = 1'b0;
        bus.SLIP   = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.RX_VAL = 1'b1;
        bus.RX_DATA = $urandom;
        bus.SLIP = 1'b1;
        bus.FEC_LOCK = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        n_tests++;
        if ({bus.BLK_DATA, bus.BLK_VAL, bus.BLK_SOB, bus.BLK_EOB, bus.T_CRC, bus.T_CRC_ENA, bus.BIT_OFS, bus.SLIP_CNT} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: data=%h val=%b sob=%b eob=%b tcrc=%h ena=%b ofs=%0d scnt=%0d required all zero",
                     bus.BLK_DATA, bus.BLK_VAL, bus.BLK_SOB, bus.BLK_EOB, bus.T_CRC, bus.T_CRC_ENA, bus.BIT_OFS, bus.SLIP_CNT);
        end
        RST = 1'b0;
        bus.RX_VAL = 1'b0;
        bus.SLIP = 1'b0;
    endtask

    task automatic test_continuous();
        int sob_cnt = 0;
        int eob_cnt = 0;
        for (int i = 0; i < 132; i++) begin
            step(1'b1, 32'(i), 1'b0, 1'b0);
            hit = (exp_q.size() != 0);
            e = '0;
            if (hit) e = exp_q.pop_front();
            sob_cnt += int'(bus.BLK_SOB === 1'b1);
            eob_cnt += int'(bus.T_CRC_ENA === 1'b1);
            n_tests++;
            if (bus.BLK_VAL !== hit || (hit && bus.BLK_DATA !== e.data)) begin
                n_fail++;
                $display("[TB] FAIL cont_word %0d: val=%b data=%h required val=%b data=%h", i, bus.BLK_VAL, bus.BLK_DATA, hit, e.data);
            end
            n_tests++;
            if ({bus.BLK_SOB, bus.BLK_EOB, bus.T_CRC_ENA, bus.T_CRC} !== {e.sob, e.eob, e.eob, m_tcrc}) begin
                n_fail++;
                $display("[TB] FAIL cont_frame %0d: sob=%b eob=%b ena=%b tcrc=%h required %b %b %b %h",
                         i, bus.BLK_SOB, bus.BLK_EOB, bus.T_CRC_ENA, bus.T_CRC, e.sob, e.eob, e.eob, m_tcrc);
            end
        end
        n_tests++;
        if (sob_cnt != 2 || eob_cnt != 2 || bus.T_CRC !== 32'd130) begin
            n_fail++;
            $display("[TB] FAIL cont_summary: sob=%0d eob=%0d tcrc=%0d required 2 2 130", sob_cnt, eob_cnt, bus.T_CRC);
        end
    endtask

    task automatic test_single_slip();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i % 2 == 0) ? 32'hAAAAAAAA : 32'h55555555, i == 3, 1'b0);
            hit = (exp_q.size() != 0);
            e = '0;
            if (hit) e = exp_q.pop_front();
            n_tests++;
            if (bus.BLK_VAL !== hit || (hit && bus.BLK_DATA !== e.data)) begin
                n_fail++;
                $display("[TB] FAIL slip1_word %0d: val=%b data=%h required val=%b data=%h", i, bus.BLK_VAL, bus.BLK_DATA, hit, e.data);
            end
            n_tests++;
            if (bus.BIT_OFS !== m_ofs || bus.SLIP_CNT !== slip_exp()) begin
                n_fail++;
                $display("[TB] FAIL slip1_ofs %0d: ofs=%0d scnt=%0d required %0d %0d", i, bus.BIT_OFS, bus.SLIP_CNT, m_ofs, slip_exp());
            end
        end
        n_tests++;
        if (bus.BIT_OFS !== 5'd1) begin
            n_fail++;
            $display("[TB] FAIL slip1_final_ofs: ofs=%0d required 1", bus.BIT_OFS);
        end
    endtask

    task automatic test_slip_wrap();
        int vals = 0;
        int emitted = 0;
        for (int i = 0; i < 132; i++) begin
            step(1'b1, $urandom, (i % 4 == 0) && (i < 128), 1'b0);
            vals++;
            hit = (exp_q.size() != 0);
            e = '0;
            if (hit) e = exp_q.pop_front();
            emitted += int'(bus.BLK_VAL === 1'b1);
            n_tests++;
            if (bus.BLK_VAL !== hit || (hit && bus.BLK_DATA !== e.data)) begin
                n_fail++;
                $display("[TB] FAIL wrap_word %0d: val=%b data=%h required val=%b data=%h", i, bus.BLK_VAL, bus.BLK_DATA, hit, e.data);
            end
            n_tests++;
            if ({bus.BLK_SOB, bus.BLK_EOB, bus.T_CRC_ENA, bus.T_CRC, bus.BIT_OFS, bus.SLIP_CNT} !==
                {e.sob, e.eob, e.eob, m_tcrc, m_ofs, slip_exp()}) begin
                n_fail++;
                $display("[TB] FAIL wrap_state %0d: sob=%b eob=%b ena=%b tcrc=%h ofs=%0d scnt=%0d required %b %b %b %h %0d %0d",
                         i, bus.BLK_SOB, bus.BLK_EOB, bus.T_CRC_ENA, bus.T_CRC, bus.BIT_OFS, bus.SLIP_CNT,
                         e.sob, e.eob, e.eob, m_tcrc, m_ofs, slip_exp());
            end
        end
        n_tests++;
        if (emitted != vals - 1 || bus.BIT_OFS !== 5'd1) begin
            n_fail++;
            $display("[TB] FAIL wrap_drop: emitted=%0d ofs=%0d required %0d 1", emitted, bus.BIT_OFS, vals - 1);
        end
    endtask

    task automatic test_ignored_slips();
        logic [15:0] scnt_before;
        step(1'b1, $urandom, 1'b1, 1'b1);
        void'(exp_q.pop_front());
        n_tests++;
        if (bus.BIT_OFS !== 5'd1) begin
            n_fail++;
            $display("[TB] FAIL locked_slip: ofs=%0d required 1", bus.BIT_OFS);
        end
        for (int i = 0; i < 31; i++) step(1'b0, '0, 1'b1, 1'b0);
        scnt_before = bus.SLIP_CNT;
        step(1'b0, '0, 1'b1, 1'b0);
        n_tests++;
        if (bus.BIT_OFS !== 5'd0 || bus.SLIP_CNT !== scnt_before || bus.SLIP_CNT !== slip_exp()) begin
            n_fail++;
            $display("[TB] FAIL pending_slip: ofs=%0d scnt=%0d required 0 %0d", bus.BIT_OFS, bus.SLIP_CNT, slip_exp());
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, $urandom, 1'b0, 1'b0);
            hit = (exp_q.size() != 0);
            e = '0;
            if (hit) e = exp_q.pop_front();
            n_tests++;
            if (bus.BLK_VAL !== hit || (hit && bus.BLK_DATA !== e.data) || bus.BLK_SOB !== e.sob) begin
                n_fail++;
                $display("[TB] FAIL drop_word %0d: val=%b data=%h sob=%b required val=%b data=%h sob=%b",
                         i, bus.BLK_VAL, bus.BLK_DATA, bus.BLK_SOB, hit, e.data, e.sob);
            end
        end
    endtask

    task automatic test_gapped();
        int ena_cnt = 0;
        for (int i = 0; i < 198; i++) begin
            step(i % 3 == 0, $urandom, 1'b0, 1'b0);
            hit = (exp_q.size() != 0);
            e = '0;
            if (hit) e = exp_q.pop_front();
            ena_cnt += int'(bus.T_CRC_ENA === 1'b1);
            n_tests++;
            if (bus.BLK_VAL !== hit || (hit && bus.BLK_DATA !== e.data)) begin
                n_fail++;
                $display("[TB] FAIL gap_word %0d: val=%b data=%h required val=%b data=%h", i, bus.BLK_VAL, bus.BLK_DATA, hit, e.data);
            end
            n_tests++;
            if ({bus.BLK_SOB, bus.BLK_EOB, bus.T_CRC_ENA, bus.T_CRC} !== {e.sob, e.eob, e.eob, m_tcrc}) begin
                n_fail++;
                $display("[TB] FAIL gap_frame %0d: sob=%b eob=%b ena=%b tcrc=%h required %b %b %b %h",
                         i, bus.BLK_SOB, bus.BLK_EOB, bus.T_CRC_ENA, bus.T_CRC, e.sob, e.eob, e.eob, m_tcrc);
            end
        end
        n_tests++;
        if (ena_cnt != 1) begin
            n_fail++;
            $display("[TB] FAIL gap_ena_count: strobes=%0d required 1", ena_cnt);
        end
    endtask

    task automatic test_reset_mid_block();
        for (int i = 0; i < 70 && m_cnt != 30; i++) begin
            step(1'b1, $urandom, 1'b0, 1'b0);
            void'(exp_q.pop_front());
        end
        RST = 1'b1;
        bus.RX_VAL = 1'b1;
        bus.RX_DATA = $urandom;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        bus.RX_VAL = 1'b0;
        model_reset();
        n_tests++;
        if ({bus.BLK_DATA, bus.BLK_VAL, bus.BLK_SOB, bus.BLK_EOB, bus.T_CRC, bus.T_CRC_ENA, bus.BIT_OFS, bus.SLIP_CNT} !== '0) begin
            n_fail++;
            $display("[TB] FAIL midrst_outputs: data=%h val=%b sob=%b eob=%b tcrc=%h ena=%b ofs=%0d scnt=%0d required all zero",
                     bus.BLK_DATA, bus.BLK_VAL, bus.BLK_SOB, bus.BLK_EOB, bus.T_CRC, bus.T_CRC_ENA, bus.BIT_OFS, bus.SLIP_CNT);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0);
            hit = (exp_q.size() != 0);
            e = '0;
            if (hit) e = exp_q.pop_front();
            n_tests++;
            if (bus.BLK_VAL !== hit || (hit && bus.BLK_DATA !== e.data) || bus.BLK_SOB !== e.sob) begin
                n_fail++;
                $display("[TB] FAIL midrst_word %0d: val=%b data=%h sob=%b required val=%b data=%h sob=%b",
                         i, bus.BLK_VAL, bus.BLK_DATA, bus.BLK_SOB, hit, e.data, e.sob);
            end
            if (i == 0) begin
                n_tests++;
                if (bus.BLK_SOB !== 1'b1 || bus.BLK_DATA !== 32'd0) begin
                    n_fail++;
                    $display("[TB] FAIL midrst_first_sob: sob=%b data=%h required 1 00000000", bus.BLK_SOB, bus.BLK_DATA);
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST = 1'b0;
        bus.RX_DATA  = '0;
        bus.RX_VAL   = 1'b0;
        bus.SLIP     = 1'b0;
        bus.FEC_LOCK = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        test_reset();
        test_continuous();
        test_single_slip();
        test_slip_wrap();
        test_ignored_slips();
        test_gapped();
        test_reset_mid_block();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
